// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants for the memory-mapped countdown timer
package timer_pkg;

    // Word offsets within the 16-byte register window (addr[3:2])
    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PRESET = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] OFS_RSVD   = 2'd3;

    // CTRL register bit positions
    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM_BIT   = 3;

    // MODE field values; 2 and 3 fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // Countdown FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Assemble the software-visible CTRL word; upper bits always read zero
    function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode, input logic im);
        logic [31:0] w;
        w = 32'd0;
        w[EN_BIT] = en;
        w[MODE_MSB:MODE_LSB] = mode;
        w[IM_BIT] = im;
        return w;
    endfunction

endpackage

// File: rtl/timer_addr_dec.sv
// rtl/timer_addr_dec.sv - bus address decode, legal-access qualification and error flag
module timer_addr_dec
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    output logic [1:0]  offset,
    output logic        rd_ok,
    output logic        wr_ctrl,
    output logic        wr_preset,
    output logic        err
);

    localparam logic [27:0] BASE_TAG = BASE_ADDR[31:4];

    logic hit;
    logic misaligned;
    logic bad_offset;

    // Window match, alignment and offset legality; an error suppresses every side effect
    always_comb begin
        hit        = (addr[31:4] == BASE_TAG);
        offset     = addr[3:2];
        misaligned = (addr[1:0] != 2'b00);
        bad_offset = (offset == OFS_RSVD) || (we && (offset == OFS_COUNT));
        err        = sel && (!hit || misaligned || bad_offset);
        rd_ok      = sel && !err;
        wr_ctrl    = sel && we && !err && (offset == OFS_CTRL);
        wr_preset  = sel && we && !err && (offset == OFS_PRESET);
    end

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - countdown timer bus responder with one-shot/auto-reload modes and irq
module timer_dev
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        err,
    output logic        irq
);

    logic [1:0]  offset;
    logic        rd_ok;
    logic        wr_ctrl;
    logic        wr_preset;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic        irq_pend;

    logic        is_reload;
    logic        int_entry;

    timer_addr_dec #(
        .BASE_ADDR (BASE_ADDR)
    ) u_dec (
        .sel       (sel),
        .we        (we),
        .addr      (addr),
        .offset    (offset),
        .rd_ok     (rd_ok),
        .wr_ctrl   (wr_ctrl),
        .wr_preset (wr_preset),
        .err       (err)
    );

    // Expiry is decided in the last CNT cycle, so the one-shot EN clear and the
    // irq_pend set land on the same edge that enters INT; that edge is where a
    // concurrent CPU CTRL write is arbitrated (CPU wins EN, set wins irq_pend).
    always_comb begin
        is_reload = (ctrl_mode == MODE_RELOAD);
        int_entry = (state == ST_CNT) && ctrl_en && (count == 32'd0);
    end

    // Countdown FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ctrl_en) state <= ST_LOAD;
                ST_LOAD: state <= ST_CNT;
                ST_CNT: begin
                    if (!ctrl_en)
                        state <= ST_IDLE;
                    else if (count == 32'd0)
                        state <= ST_INT;
                end
                default: state <= is_reload ? ST_LOAD : ST_IDLE;
            endcase
        end
    end

    // COUNT: loaded from PRESET in LOAD, decremented only while nonzero so it never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else if (state == ST_LOAD) begin
            count <= preset;
        end else if ((state == ST_CNT) && ctrl_en && (count != 32'd0)) begin
            count <= count - 32'd1;
        end
    end

    // CTRL fields; a CPU write overrides the hardware EN clear at one-shot expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= wdata[EN_BIT];
            ctrl_mode <= wdata[MODE_MSB:MODE_LSB];
            ctrl_im   <= wdata[IM_BIT];
        end else if (int_entry && !is_reload) begin
            ctrl_en   <= 1'b0;
        end
    end

    // PRESET is only consumed in LOAD, so a write mid-count affects the next period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= wdata;
        end
    end

    // Pending interrupt: set on INT entry; cleared by a CTRL write, or one cycle later in reload mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pend <= 1'b0;
        end else if (int_entry) begin
            irq_pend <= 1'b1;
        end else if (wr_ctrl || ((state == ST_INT) && is_reload)) begin
            irq_pend <= 1'b0;
        end
    end

    // Registered, masked interrupt request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_pend && ctrl_im;
        end
    end

    // Combinational read mux; zero for deselected or erroneous accesses
    always_comb begin
        rdata = 32'd0;
        if (rd_ok) begin
            case (offset)
                OFS_CTRL:   rdata = ctrl_word(ctrl_en, ctrl_mode, ctrl_im);
                OFS_PRESET: rdata = preset;
                OFS_COUNT:  rdata = count;
                default:    rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev
module tb_timer_dev;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        err;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timer_dev #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .err   (err),
        .irq   (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ra(input int off);
        return BASE + 32'(off) * 32'd4;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expv);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(tag, rdata, expv);
        sel = 1'b0;
    endtask

    // Bus access expected to be rejected: err=1, rdata=0, then it is clocked through
    task automatic bad_acc(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d);
        sel = 1'b1; we = w; addr = a; wdata = d;
        #1;
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_rdata"}, rdata, 32'd0);
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    // Countdown reference: EN written at k=0, COUNT=P at k=2, minus one per cycle, floor at 0
    function automatic logic [31:0] cnt_model(input int p, input int k, input logic [31:0] old);
        if (k < 2) return old;
        if (k - 2 >= p) return 32'd0;
        return 32'(p - (k - 2));
    endfunction

    logic [31:0] ctrl_m, preset_m, count_m, a, d, exp_rd;
    logic        s, w, e, hit;
    logic [1:0]  off;

    initial begin
        // Reset mid-count
        tick(2);
        @(negedge clk) reset = 1'b1;
        tick(1);
        wr(ra(1), 32'd10);
        wr(ra(0), 32'h1);
        tick(7);
        rd_chk("pre_reset_count", ra(2), cnt_model(10, 7, 0));
        #2 reset = 1'b0;
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_count", ra(2), 32'd0);
        rd_chk("rst_ctrl", ra(0), 32'd0);
        rd_chk("rst_preset", ra(1), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick(1);
        rd_chk("post_rst_ofs8", ra(2), 32'd0);
        chk("post_rst_irq", 32'(irq), 32'd0);

        // One-shot, PRESET=3: INT entered at k=P+3, irq from k=P+4
        wr(ra(1), 32'd3);
        wr(ra(0), 32'h9);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            rd_chk($sformatf("os_count_k%0d", k), ra(2), cnt_model(3, k, 0));
            rd_chk($sformatf("os_ctrl_k%0d", k), ra(0), (k >= 6) ? 32'h8 : 32'h9);
            chk($sformatf("os_irq_k%0d", k), 32'(irq), (k >= 7) ? 32'd1 : 32'd0);
        end
        wr(ra(0), 32'h8);
        tick(1);
        chk("os_irq_cleared", 32'(irq), 32'd0);

        // Auto-reload, PRESET=2: period P+3=5, irq pulse one cycle after each INT entry
        wr(ra(1), 32'd2);
        wr(ra(0), 32'hB);
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk($sformatf("ar_irq_k%0d", k), 32'(irq),
                (k >= 6 && (k - 6) % 5 == 0) ? 32'd1 : 32'd0);
            if (k >= 2)
                rd_chk($sformatf("ar_count_k%0d", k), ra(2),
                       ((k - 2) % 5 <= 2) ? 32'(2 - (k - 2) % 5) : 32'd0);
        end
        wr(ra(0), 32'h0);
        tick(3);
        chk("ar_stopped_irq", 32'(irq), 32'd0);

        // Pause at COUNT=4 by clearing EN
        wr(ra(1), 32'd10);
        wr(ra(0), 32'h9);
        tick(7);
        wr(ra(0), 32'h8);
        for (int k = 0; k < 5; k++) begin
            rd_chk($sformatf("pause_count_%0d", k), ra(2), 32'd4);
            chk($sformatf("pause_irq_%0d", k), 32'(irq), 32'd0);
            tick(1);
        end

        // PRESET=0: INT at t3, irq at t4
        wr(ra(1), 32'd0);
        wr(ra(0), 32'h9);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk($sformatf("p0_irq_k%0d", k), 32'(irq), (k >= 4) ? 32'd1 : 32'd0);
            rd_chk($sformatf("p0_count_k%0d", k), ra(2), cnt_model(0, k, 4));
        end
        wr(ra(0), 32'h0);
        tick(1);
        chk("p0_irq_cleared", 32'(irq), 32'd0);

        // IM=0: no irq, but CTRL/COUNT still show expiry
        wr(ra(1), 32'd1);
        wr(ra(0), 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk($sformatf("im0_irq_k%0d", k), 32'(irq), 32'd0);
            rd_chk($sformatf("im0_ctrl_k%0d", k), ra(0), (k >= 4) ? 32'h0 : 32'h1);
        end
        rd_chk("im0_count", ra(2), 32'd0);
        wr(ra(0), 32'h0);

        // Erroneous accesses: flagged, no side effect
        wr(ra(1), 32'h1234);
        wr(ra(0), 32'h6);
        bad_acc("wr_count", ra(2), 1'b1, 32'h55);
        bad_acc("rd_rsvd", ra(3), 1'b0, 32'h0);
        bad_acc("wr_rsvd", ra(3), 1'b1, 32'hFF);
        bad_acc("wr_misalign", BASE + 32'd2, 1'b1, 32'h9);
        bad_acc("wr_misalign_pre", ra(1) + 32'd1, 1'b1, 32'h77);
        bad_acc("wr_outside", BASE + 32'h10, 1'b1, 32'h9);
        bad_acc("wr_alias", BASE + 32'h14, 1'b1, 32'hDEAD);
        tick(2);
        rd_chk("err_ctrl_kept", ra(0), 32'h6);
        rd_chk("err_preset_kept", ra(1), 32'h1234);
        rd_chk("err_count_kept", ra(2), 32'd0);
        chk("err_irq", 32'(irq), 32'd0);
        sel = 1'b0; we = 1'b0; addr = ra(1);
        #1;
        chk("nosel_err", 32'(err), 32'd0);
        chk("nosel_rdata", rdata, 32'd0);
        sel = 1'b1;
        #1;
        chk("legal_rd_err", 32'(err), 32'd0);
        sel = 1'b0;

        // Collision: CTRL=0x9 written on the edge that enters one-shot INT
        wr(ra(1), 32'd3);
        wr(ra(0), 32'h9);
        tick(5);
        wr(ra(0), 32'h9);
        rd_chk("col_ctrl_t6", ra(0), 32'h9);
        tick(1);
        chk("col_irq_t7", 32'(irq), 32'd1);
        rd_chk("col_ctrl_t7", ra(0), 32'h9);
        wr(ra(0), 32'h8);
        tick(3);
        chk("col_irq_cleared", 32'(irq), 32'd0);

        // Random register traffic against a register-level model (EN kept 0)
        ctrl_m = 32'h8; preset_m = 32'd3; count_m = 32'd3;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = ra(int'($urandom_range(0, 3)));
                3:       a = ra(int'($urandom_range(0, 3))) + 32'($urandom_range(1, 3));
                4:       a = BASE ^ (32'd1 << $urandom_range(4, 31));
                default: a = $urandom;
            endcase
            s = ($urandom_range(0, 7) != 0);
            w = 1'($urandom_range(0, 1));
            d = $urandom & 32'hFFFF_FFFE;
            hit = (a[31:4] == BASE[31:4]);
            off = a[3:2];
            e = s && (!hit || a[1:0] != 2'b00 || off == 2'd3 || (w && off == 2'd2));
            case (off)
                2'd0:    exp_rd = ctrl_m;
                2'd1:    exp_rd = preset_m;
                2'd2:    exp_rd = count_m;
                default: exp_rd = 32'd0;
            endcase
            if (!s || e) exp_rd = 32'd0;
            sel = s; we = w; addr = a; wdata = d;
            #1;
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(e));
            if (!w || e)
                chk($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
            @(posedge clk);
            #1;
            sel = 1'b0; we = 1'b0;
            if (s && w && !e && off == 2'd0) ctrl_m = d & 32'hF;
            if (s && w && !e && off == 2'd1) preset_m = d;
            chk($sformatf("rnd%0d_irq", i), 32'(irq), 32'd0);
        end
        rd_chk("rnd_final_ctrl", ra(0), ctrl_m);
        rd_chk("rnd_final_preset", ra(1), preset_m);
        rd_chk("rnd_final_count", ra(2), count_m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer that acts as a responder on the CPU data bus.
- Driven by the M-stage load/store path through the system bridge: byte address, write enable and write data come in; read data and an access-error flag go back.
- Raises an interrupt request toward the CP0/exception logic when the count expires.
- Supports one-shot and auto-reload modes.

Parameters:
BASE_ADDR, 32'h0000_7F00, device base byte address; bits [3:0] must be zero.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low (0 = reset)
sel  input  1  bridge selects this device this cycle
addr  input  32  byte address of access
we  input  1  store strobe, qualified by sel
wdata  input  32  store data
rdata  output  32  load data, combinational from addr
err  output  1  illegal access, combinational; feeds exception logic
irq  output  1  interrupt request, registered

Behaviour:
- Register map, selected by addr[3:2] when addr[31:4]==BASE_ADDR[31:4]:
  - 0 = CTRL, R/W: bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read 0 and ignore writes.
  - 1 = PRESET, R/W, 32 bits.
  - 2 = COUNT, read-only.
  - 3 = reserved.
- Legal write: sel & we & hit & addr[1:0]==0 & offset in {0,1}. It updates the register at the clock edge.
- err = sel & (~hit | addr[1:0]!=0 | offset==3 | (we & offset==2)).
  - An erroneous access has no side effect and returns rdata=0.
- rdata: register value for a legal read; 0 otherwise, including when sel=0.
- Reset (asynchronous, immediate, also mid-count):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0, irq=0.
  - rdata therefore reads 0 at every offset.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1 -> LOAD; COUNT holds.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT: if EN=0 -> IDLE, COUNT frozen. Else if COUNT==0 -> INT. Else COUNT<=COUNT-1.
  - INT, MODE=0 (one-shot): hardware clears EN; -> IDLE.
  - INT, MODE=1 (auto-reload): -> LOAD.
  - MODE 2/3 behave as MODE 0.
- Timing: EN written at edge t0 gives LOAD at t1, COUNT=PRESET at t2, COUNT=0 at t2+N, INT at t2+N+1. PRESET=0 therefore goes to INT at t3.
- COUNT never wraps: decrement happens only when nonzero.
- irq_pend:
  - Set on the edge entering INT.
  - MODE 0: stays set until any legal CTRL write clears it.
  - MODE 1: cleared automatically one cycle later, so irq is a one-cycle pulse.
- irq = irq_pend & IM, registered output.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears EN: the CPU value wins.
  - A CTRL write that sets irq_pend's clear condition in the INT-entry cycle: the set wins.
  - A PRESET write during CNT takes effect at the next LOAD only.
  - A MODE change during CNT takes effect at INT.

Decomposition:
- Package timer_pkg holds:
  - offset constants OFS_CTRL, OFS_PRESET, OFS_COUNT
  - CTRL bit positions EN_BIT, IM_BIT, MODE_LSB/MSB
  - mode constants MODE_ONESHOT, MODE_RELOAD
  - the 2-bit FSM state encoding
- One natural sub-module, timer_addr_dec: combinational hit/offset/legal-write/err decode.
- The FSM and register file stay in timer_dev.

Test Plan:
1. Reset: reset=0 mid-count with COUNT=5 -> all outputs 0 immediately; after release, read offset 8 -> rdata=0, irq=0.
2. One-shot: write PRESET=3, then CTRL=0x9 (EN, IM, MODE0) -> COUNT reads 3,2,1,0; irq rises the edge after INT and stays 1; CTRL reads 0x8; write CTRL=0x8 -> irq=0 next cycle.
3. Auto-reload: PRESET=2, CTRL=0xB -> irq is a 1-cycle pulse every 5 cycles, repeating with no CPU action.
4. Pause/edge cases:
   - EN=0 during CNT at COUNT=4 -> COUNT frozen at 4, state IDLE.
   - PRESET=0 with EN -> irq at t3.
   - IM=0 -> irq stays 0 while the read path still shows expiry.
5. Errors, each giving err=1 and no state change:
   - write to BASE+8
   - access to BASE+0xC
   - addr=BASE+2
   - addr outside the 16-byte window
   - Control: sel=0 -> err=0 and rdata=0.
6. Collision: a CTRL write of 0x9 in the same cycle as one-shot INT -> EN remains 1 and irq_pend is set.
